pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 16 +
 rtl/pc_next_adder.sv | 13 +
 rtl/pc_sequencer.sv | 141 ++++++++++++++
 tb/tb_pc_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the instruction-fetch PC sequencer.
package pc_seq_pkg;

  localparam int PC_WIDTH = 16;

  localparam logic [PC_WIDTH-1:0] DEF_RESET_VECTOR = 16'h0000;
  localparam logic [PC_WIDTH-1:0] DEF_PC_STEP      = 16'h0001;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/pc_next_adder.sv
// Wrap-around PC adder, shared by sequential increment and relative redirect.
// Purely combinational, no backpressure.
module pc_next_adder
  import pc_seq_pkg::*;
(
  input  logic [PC_WIDTH-1:0] i_a,
  input  logic [PC_WIDTH-1:0] i_b,
  output logic [PC_WIDTH-1:0] o_sum
);

  assign o_sum = i_a + i_b;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer: requests imem at pc, offers the word to decode one cycle after ack.
// Decode backpressure holds the offer and stalls fetching; redirects kill in-flight data.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [PC_WIDTH-1:0] PC_STEP      = DEF_PC_STEP
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [PC_WIDTH-1:0] imem_data,
  output logic                instr_valid,
  output logic [PC_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0] instr_pc,
  input  logic                instr_ready,
  input  logic                br_valid,
  input  logic                br_rel,
  input  logic [PC_WIDTH-1:0] br_target,
  input  logic                halt_req,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_last_pc;
  logic [PC_WIDTH-1:0] r_addr;
  logic [PC_WIDTH-1:0] r_instr;
  logic [PC_WIDTH-1:0] r_instr_pc;
  logic                r_kill;
  logic                r_halt_lat;

  logic                w_br;
  logic                w_xfer;
  logic                w_halt_eff;
  logic                w_capture;
  logic                w_last_ld;
  logic                w_addr_ld;
  logic                w_kill_nxt;
  logic [PC_WIDTH-1:0] w_add_a;
  logic [PC_WIDTH-1:0] w_add_b;
  logic [PC_WIDTH-1:0] w_sum;
  logic [PC_WIDTH-1:0] w_redir;
  logic [PC_WIDTH-1:0] w_pc_nxt;

  assign w_br       = br_valid && (r_state == ST_REQ || r_state == ST_ISSUE);
  assign w_xfer     = (r_state == ST_ISSUE) && instr_ready;
  assign w_halt_eff = r_halt_lat || halt_req;

  // One adder: relative redirect needs last_pc+offset, otherwise pc+step.
  assign w_add_a = w_br ? r_last_pc : r_pc;
  assign w_add_b = w_br ? br_target : PC_STEP;

  pc_next_adder u_adder (
    .i_a  (w_add_a),
    .i_b  (w_add_b),
    .o_sum(w_sum)
  );

  assign w_redir = br_rel ? w_sum : br_target;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_capture   = 1'b0;
    w_last_ld   = 1'b0;
    w_kill_nxt  = r_kill;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (w_br) w_pc_nxt = w_redir;
        if (imem_ack) begin
          w_kill_nxt = 1'b0;
          if (w_halt_eff) begin
            w_state_nxt = ST_HALT;
          end else if (!r_kill && !w_br) begin
            w_state_nxt = ST_ISSUE;
            w_capture   = 1'b1;
          end
        end else if (w_br) begin
          w_kill_nxt = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (w_br) begin
          w_pc_nxt    = w_redir;
          w_state_nxt = w_halt_eff ? ST_HALT : ST_REQ;
        end else if (w_xfer) begin
          w_pc_nxt    = w_sum;
          w_last_ld   = 1'b1;
          w_state_nxt = w_halt_eff ? ST_HALT : ST_REQ;
        end
      end
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // The fetch address only moves when a new request starts, keeping it stable while one is outstanding.
  assign w_addr_ld = (w_state_nxt == ST_REQ) && ((r_state != ST_REQ) || imem_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_BOOT;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_VECTOR;
      r_last_pc  <= RESET_VECTOR;
      r_addr     <= RESET_VECTOR;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_kill     <= 1'b0;
      r_halt_lat <= 1'b0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_kill <= w_kill_nxt;
      if (halt_req)  r_halt_lat <= 1'b1;
      if (w_last_ld) r_last_pc  <= r_instr_pc;
      if (w_addr_ld) r_addr     <= w_pc_nxt;
      if (w_capture) begin
        r_instr    <= imem_data;
        r_instr_pc <= r_addr;
      end
    end
  end

  assign imem_req    = (r_state == ST_REQ);
  assign imem_addr   = r_addr;
  assign instr_valid = (r_state == ST_ISSUE);
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign pc          = r_pc;
  assign halted      = (r_state == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scenarios plus randomized traffic checked against a transaction-level fetch model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = '0;
  logic        instr_ready = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_rel = 1'b0;
  logic [15:0] br_target = '0;
  logic        halt_req = 1'b0;

  logic        imem_req, instr_valid, halted;
  logic [15:0] imem_addr, instr, instr_pc, pc;
  logic        w_imem_req, w_instr_valid, w_halted;
  logic [15:0] w_imem_addr, w_instr, w_instr_pc, w_pc;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          m_boot, m_fetching, m_offering, m_halted, m_discard, m_hlat;
  logic [15:0] m_pc, m_last, m_fetch_addr, m_instr, m_ipc;

  always #5 clk = ~clk;

  pc_sequencer u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .br_valid(br_valid), .br_rel(br_rel), .br_target(br_target), .halt_req(halt_req),
    .pc(pc), .halted(halted)
  );

  pc_sequencer #(.RESET_VECTOR(16'hFFFF), .PC_STEP(16'h0001)) u_dut_w (
    .clk(clk), .rst(rst),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .instr_valid(w_instr_valid), .instr(w_instr), .instr_pc(w_instr_pc), .instr_ready(instr_ready),
    .br_valid(br_valid), .br_rel(br_rel), .br_target(br_target), .halt_req(halt_req),
    .pc(w_pc), .halted(w_halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_ack = 0; imem_data = '0; instr_ready = 0;
    br_valid = 0; br_rel = 0; br_target = '0; halt_req = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: req=%b valid=%b halted=%b, want 0 0 0", imem_req, instr_valid, halted);
    end
    total++;
    if (pc !== 16'h0000 || imem_addr !== 16'h0000) begin
      bad++;
      $display("FAIL reset_pc: pc=%h addr=%h, want 0000 0000", pc, imem_addr);
    end
    total++;
    if (instr !== 16'h0000 || instr_pc !== 16'h0000) begin
      bad++;
      $display("FAIL reset_instr: instr=%h instr_pc=%h, want 0000 0000", instr, instr_pc);
    end
    total++;
    if (w_pc !== 16'hFFFF || w_imem_addr !== 16'hFFFF || w_imem_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_vector: pc=%h addr=%h req=%b, want ffff ffff 0", w_pc, w_imem_addr, w_imem_req);
    end
  endtask

  task automatic test_sequential();
    apply_reset();
    instr_ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 16'(k)) begin
        bad++;
        $display("FAIL seq_req[%0d]: req=%b addr=%h, want 1 %h", k, imem_req, imem_addr, 16'(k));
      end
      tick();
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 16'(k) || instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL seq_hold[%0d]: req=%b addr=%h valid=%b, want 1 %h 0", k, imem_req, imem_addr, instr_valid, 16'(k));
      end
      imem_ack = 1; imem_data = 16'hA000 + 16'(k);
      tick();
      imem_ack = 0;
      total++;
      if (instr_valid !== 1'b1 || instr !== 16'hA000 + 16'(k) || instr_pc !== 16'(k)) begin
        bad++;
        $display("FAIL seq_issue[%0d]: valid=%b instr=%h pc=%h, want 1 %h %h", k, instr_valid, instr, instr_pc, 16'hA000 + 16'(k), 16'(k));
      end
    end
  endtask

  task automatic test_abs_branch_kill();
    apply_reset();
    tick();
    br_valid = 1; br_rel = 0; br_target = 16'h0005; imem_ack = 1; imem_data = 16'hDEAD;
    tick();
    br_valid = 0; imem_ack = 0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0005 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL br_with_ack: req=%b addr=%h valid=%b, want 1 0005 0", imem_req, imem_addr, instr_valid);
    end
    imem_ack = 1; imem_data = 16'h5555; instr_ready = 1;
    tick();
    imem_ack = 0;
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0005 || instr !== 16'h5555) begin
      bad++;
      $display("FAIL abs_issue5: valid=%b pc=%h instr=%h, want 1 0005 5555", instr_valid, instr_pc, instr);
    end
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0006) begin
      bad++;
      $display("FAIL abs_req6: req=%b addr=%h, want 1 0006", imem_req, imem_addr);
    end
    br_valid = 1; br_target = 16'h1234;
    tick();
    br_valid = 0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0006 || pc !== 16'h1234) begin
      bad++;
      $display("FAIL kill_hold: req=%b addr=%h pc=%h, want 1 0006 1234", imem_req, imem_addr, pc);
    end
    imem_ack = 1; imem_data = 16'hBAD0;
    tick();
    imem_ack = 0;
    total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h1234) begin
      bad++;
      $display("FAIL kill_discard: valid=%b req=%b addr=%h, want 0 1 1234", instr_valid, imem_req, imem_addr);
    end
    imem_ack = 1; imem_data = 16'h1111;
    tick();
    imem_ack = 0;
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h1234 || instr !== 16'h1111) begin
      bad++;
      $display("FAIL redirect_issue: valid=%b pc=%h instr=%h, want 1 1234 1111", instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_rel_branch();
    apply_reset();
    instr_ready = 1;
    tick();
    br_valid = 1; br_rel = 0; br_target = 16'h0010; imem_ack = 1;
    tick();
    br_valid = 0;
    imem_data = 16'h0A10;
    tick();
    imem_ack = 0;
    tick();
    imem_ack = 1; imem_data = 16'h0A11;
    tick();
    imem_ack = 0;
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0011) begin
      bad++;
      $display("FAIL rel_setup: valid=%b pc=%h, want 1 0011", instr_valid, instr_pc);
    end
    br_valid = 1; br_rel = 1; br_target = 16'hFFFC;
    tick();
    br_valid = 0; br_rel = 0;
    total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h000C || pc !== 16'h000C) begin
      bad++;
      $display("FAIL rel_redirect: valid=%b req=%b addr=%h pc=%h, want 0 1 000c 000c", instr_valid, imem_req, imem_addr, pc);
    end
  endtask

  task automatic test_stall();
    logic [15:0] hold_instr, hold_pc;
    apply_reset();
    tick();
    imem_ack = 1; imem_data = 16'h7E57;
    tick();
    imem_ack = 0;
    hold_instr = 16'h7E57;
    hold_pc    = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== hold_instr || instr_pc !== hold_pc) begin
        bad++;
        $display("FAIL stall[%0d]: valid=%b req=%b instr=%h pc=%h, want 1 0 %h %h", i, instr_valid, imem_req, instr, instr_pc, hold_instr, hold_pc);
      end
    end
    instr_ready = 1;
    tick();
    total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0001) begin
      bad++;
      $display("FAIL stall_release: valid=%b req=%b addr=%h, want 0 1 0001", instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    instr_ready = 1;
    tick();
    imem_ack = 1; imem_data = 16'h4242;
    tick();
    imem_ack = 0;
    total++;
    if (w_instr_valid !== 1'b1 || w_instr_pc !== 16'hFFFF) begin
      bad++;
      $display("FAIL wrap_issue: valid=%b pc=%h, want 1 ffff", w_instr_valid, w_instr_pc);
    end
    tick();
    total++;
    if (w_imem_req !== 1'b1 || w_imem_addr !== 16'h0000 || w_pc !== 16'h0000) begin
      bad++;
      $display("FAIL wrap_next: req=%b addr=%h pc=%h, want 1 0000 0000", w_imem_req, w_imem_addr, w_pc);
    end
  endtask

  task automatic test_halt();
    apply_reset();
    instr_ready = 1;
    tick();
    halt_req = 1;
    tick();
    halt_req = 0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || halted !== 1'b0) begin
      bad++;
      $display("FAIL halt_pending: req=%b addr=%h halted=%b, want 1 0000 0", imem_req, imem_addr, halted);
    end
    imem_ack = 1; imem_data = 16'h1234;
    tick();
    imem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL halt_state[%0d]: halted=%b req=%b valid=%b, want 1 0 0", i, halted, imem_req, instr_valid);
      end
      tick();
    end
    br_valid = 1; br_target = 16'h4321;
    tick();
    br_valid = 0;
    tick();
    total++;
    if (pc !== 16'h0000 || halted !== 1'b1) begin
      bad++;
      $display("FAIL halt_br_ignored: pc=%h halted=%b, want 0000 1", pc, halted);
    end
    apply_reset();
    total++;
    if (halted !== 1'b0 || imem_req !== 1'b0 || pc !== 16'h0000) begin
      bad++;
      $display("FAIL halt_reset: halted=%b req=%b pc=%h, want 0 0 0000", halted, imem_req, pc);
    end
    tick();
    @(negedge clk);
    rst = 1;
    #1;
    total++;
    if (imem_req !== 1'b0) begin
      bad++;
      $display("FAIL async_drop: req=%b, want 0", imem_req);
    end
    tick();
    rst = 0;
    imem_ack = 1; imem_data = 16'hFFFF;
    tick();
    imem_ack = 0;
    total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      bad++;
      $display("FAIL boot_ack_ignored: valid=%b req=%b addr=%h, want 0 1 0000", instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic m_reset();
    m_boot = 1; m_fetching = 0; m_offering = 0; m_halted = 0; m_discard = 0; m_hlat = 0;
    m_pc = 16'h0000; m_last = 16'h0000; m_fetch_addr = 16'h0000; m_instr = '0; m_ipc = '0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic m_step();
    logic [15:0] redir;
    bit          stop;
    redir = br_rel ? 16'(m_last + br_target) : br_target;
    stop  = m_hlat || halt_req;
    if (m_boot) begin
      m_boot = 0; m_fetching = 1; m_fetch_addr = m_pc;
    end else if (m_fetching) begin
      if (br_valid) m_pc = redir;
      if (imem_ack) begin
        if (stop) begin
          m_fetching = 0; m_halted = 1;
        end else if (m_discard || br_valid) begin
          m_fetch_addr = m_pc;
        end else begin
          m_fetching = 0; m_offering = 1; m_instr = imem_data; m_ipc = m_fetch_addr;
        end
        m_discard = 0;
      end else if (br_valid) begin
        m_discard = 1;
      end
    end else if (m_offering && (br_valid || instr_ready)) begin
      if (br_valid) m_pc = redir;
      else begin
        m_last = m_ipc;
        m_pc   = 16'(m_ipc + 16'h0001);
      end
      m_offering = 0;
      if (stop) m_halted = 1;
      else begin
        m_fetching = 1; m_fetch_addr = m_pc;
      end
    end
    if (halt_req) m_hlat = 1;
  endtask

  task automatic test_random();
    apply_reset();
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      if (m_halted && $urandom_range(0, 3) == 0) begin
        apply_reset();
        m_reset();
      end else begin
        imem_ack    = ($urandom_range(0, 1) == 1);
        imem_data   = 16'($urandom);
        instr_ready = ($urandom_range(0, 9) < 6);
        br_valid    = ($urandom_range(0, 7) == 0);
        br_rel      = ($urandom_range(0, 1) == 1);
        br_target   = 16'($urandom);
        halt_req    = ($urandom_range(0, 149) == 0);
        m_step();
        tick();
      end
      total++;
      if (imem_req !== m_fetching || (m_fetching && imem_addr !== m_fetch_addr)) begin
        bad++;
        $display("FAIL rnd_fetch@%0d: req=%b addr=%h, want %b %h", c, imem_req, imem_addr, m_fetching, m_fetch_addr);
      end
      total++;
      if (instr_valid !== m_offering || (m_offering && (instr !== m_instr || instr_pc !== m_ipc))) begin
        bad++;
        $display("FAIL rnd_offer@%0d: valid=%b instr=%h pc=%h, want %b %h %h", c, instr_valid, instr, instr_pc, m_offering, m_instr, m_ipc);
      end
      total++;
      if (pc !== m_pc || halted !== m_halted) begin
        bad++;
        $display("FAIL rnd_pc@%0d: pc=%h halted=%b, want %h %b", c, pc, halted, m_pc, m_halted);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_abs_branch_kill();
    test_rel_branch();
    test_stall();
    test_wrap();
    test_halt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
